// File: rtl/mask_rand_pkg.sv
// Shared definitions for the masking randomness generator: LFSR geometry,
// feedback taps, zero-seed substitute, default warm-up length and FSM states.
package mask_rand_pkg;

   localparam int LFSR_W         = 32;
   localparam int TAP_A          = 31;
   localparam int TAP_B          = 21;
   localparam int TAP_C          = 1;
   localparam int TAP_D          = 0;
   localparam int STEPS_PER_ADV  = 8;
   localparam int WARMUP_DEFAULT = 64;
   localparam int CNT_W          = 8;

   // An all-zero Fibonacci LFSR locks up, so a zero seed is replaced by this.
   localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   // One Fibonacci shift: feedback enters at the LSB.
   function automatic logic [LFSR_W-1:0] lfsr_step1(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage

// File: rtl/mask_rand_gen_lfsr_step8.sv
// Purely combinational eight-step LFSR advance, so one clock edge moves the
// generator past every bit the two randomness nibbles consume.
module lfsr_step8
   import mask_rand_pkg::*;
(
   input  logic [31:0] s_in,
   output logic [31:0] s_out
);

   // Chain eight single steps of the feedback function.
   always_comb begin
      logic [31:0] t;
      t = s_in;
      for (int i = 0; i < STEPS_PER_ADV; i++) begin
         t = lfsr_step1(t);
      end
      s_out = t;
   end

endmodule

// File: rtl/mask_rand_gen.sv
// Fresh-randomness source for the masked GF(4) S-box pair. A seed is loaded
// through a valid/ready handshake, the LFSR is warmed up for WARMUP advances,
// then one 8-bit draw per consumed cycle is split into the A and B nibbles.
module mask_rand_gen
   import mask_rand_pkg::*;
#(
   parameter int WARMUP = WARMUP_DEFAULT
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_valid,
   input  logic [31:0] seed,
   output logic        seed_ready,
   input  logic        en,
   output logic [3:0]  ra3ra2ra1ra0,
   output logic [3:0]  rb3rb2rb1rb0,
   output logic        rnd_valid
);

   localparam logic [CNT_W-1:0] WARMUP_C = CNT_W'(WARMUP);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        s_q, s_d;
   logic [31:0]        s_adv;
   logic               rnd_valid_q;
   logic               seed_ready_q;
   logic               accept;

   lfsr_step8 u_step8 (
      .s_in  (s_q),
      .s_out (s_adv)
   );

   assign accept = seed_valid & seed_ready_q;

   // Next-state logic; a seed load always wins over an en-driven advance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               s_d     = (seed == 32'h0) ? ZERO_SEED_SUB : seed;
               cnt_d   = '0;
               state_d = ST_WARMUP;
            end
         end
         ST_WARMUP: begin
            // WARMUP advances, then one more edge to hand over to RUN.
            if (cnt_q != WARMUP_C) begin
               s_d   = s_adv;
               cnt_d = cnt_q + 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               s_d     = (seed == 32'h0) ? ZERO_SEED_SUB : seed;
               cnt_d   = '0;
               state_d = ST_WARMUP;
            end else if (en) begin
               s_d = s_adv;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter, LFSR and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         s_q          <= '0;
         rnd_valid_q  <= 1'b0;
         seed_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s_q          <= s_d;
         rnd_valid_q  <= (state_d == ST_RUN);
         seed_ready_q <= (state_d != ST_WARMUP);
      end
   end

   // Outputs are flop bits, the nibbles gated by the registered valid flag.
   assign rnd_valid    = rnd_valid_q;
   assign seed_ready   = seed_ready_q;
   assign ra3ra2ra1ra0 = s_q[3:0] & {4{rnd_valid_q}};
   assign rb3rb2rb1rb0 = s_q[7:4] & {4{rnd_valid_q}};

endmodule

// File: tb/tb_mask_rand_gen.sv
// Directed and random checks of mask_rand_gen against a behavioural model of
// the generator: an expected LFSR value plus an expected "randomness usable" flag.
module tb_mask_rand_gen;

   localparam int RAND_CYCLES = 20000;

   logic        clk;
   logic        rst_n;

   logic        sv1, sr1, en1, rv1;
   logic [31:0] sd1;
   logic [3:0]  ra1, rb1;

   logic        sv, sr, en, rv;
   logic [31:0] sd;
   logic [3:0]  ra, rb;

   int ncmp  = 0;
   int nfail = 0;

   logic [31:0] m_s;
   logic [31:0] prev_s;
   logic        m_run;

   mask_rand_gen #(.WARMUP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .seed_valid(sv1), .seed(sd1), .seed_ready(sr1),
      .en(en1), .ra3ra2ra1ra0(ra1), .rb3rb2rb1rb0(rb1), .rnd_valid(rv1)
   );

   mask_rand_gen #(.WARMUP(64)) dut (
      .clk(clk), .rst_n(rst_n), .seed_valid(sv), .seed(sd), .seed_ready(sr),
      .en(en), .ra3ra2ra1ra0(ra), .rb3rb2rb1rb0(rb), .rnd_valid(rv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference advance: eight applications of the documented feedback rule.
   function automatic logic [31:0] ref_adv(input logic [31:0] s);
      logic [31:0] t;
      t = s;
      for (int i = 0; i < 8; i++) begin
         t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
      end
      return t;
   endfunction

   function automatic logic [31:0] ref_warm(input logic [31:0] seed_in, input int n);
      logic [31:0] t;
      t = (seed_in == 32'h0) ? 32'h1 : seed_in;
      for (int i = 0; i < n; i++) t = ref_adv(t);
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Nibbles and valid as the model predicts them from m_s / m_run.
   task automatic chk_out(input string tag);
      chk({tag, "_valid"}, {31'h0, rv}, {31'h0, m_run});
      chk({tag, "_ra"}, {28'h0, ra}, m_run ? {28'h0, m_s[3:0]} : 32'h0);
      chk({tag, "_rb"}, {28'h0, rb}, m_run ? {28'h0, m_s[7:4]} : 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      sv1 = 1'b0; sd1 = '0; en1 = 1'b0;
      sv  = 1'b0; sd  = '0; en  = 1'b0;
      m_run = 1'b0; m_s = '0;
      #12;
      chk("rst_valid", {31'h0, rv}, 32'h0);
      chk("rst_ready", {31'h0, sr}, 32'h1);
      chk("rst_ra", {28'h0, ra}, 32'h0);
      chk("rst_rb", {28'h0, rb}, 32'h0);
      chk("rst_s1", dut1.s_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // WARMUP=1 instance, zero seed, with en high to show it is ignored.
      sv1 = 1'b1; sd1 = 32'h0; en1 = 1'b1;
      tick();
      sv1 = 1'b0;
      chk("w1_valid_e0", {31'h0, rv1}, 32'h0);
      chk("w1_ready_e0", {31'h0, sr1}, 32'h0);
      chk("w1_s_e0", dut1.s_q, 32'h1);
      tick();
      chk("w1_valid_e1", {31'h0, rv1}, 32'h0);
      tick();
      chk("w1_valid_e2", {31'h0, rv1}, 32'h1);
      chk("w1_s_e2", dut1.s_q, 32'h0000_01B6);
      chk("w1_ra", {28'h0, ra1}, 32'h6);
      chk("w1_rb", {28'h0, rb1}, 32'hB);
      en1 = 1'b0;

      // WARMUP=64 instance, seed 1; seed pulses during warm-up must be refused.
      sv = 1'b1; sd = 32'h1;
      tick();
      sv = 1'b0;
      for (int k = 1; k <= 65; k++) begin
         if (k == 10 || k == 40) begin
            sv = 1'b1; sd = 32'h1234_5678;
         end
         chk("w64_ready_low", {31'h0, sr}, 32'h0);
         tick();
         sv = 1'b0;
         chk($sformatf("w64_valid_k%0d", k), {31'h0, rv}, (k == 65) ? 32'h1 : 32'h0);
      end
      m_s = ref_warm(32'h1, 64);
      m_run = 1'b1;
      chk("w64_s", dut.s_q, m_s);
      chk_out("w64_out");

      // Hold for 10 cycles, then three advances.
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk_out("hold");
      end
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         prev_s = m_s;
         tick();
         m_s = ref_adv(m_s);
         chk_out("adv");
         chk("adv_s", dut.s_q, m_s);
         chk("adv_distinct", {31'h0, dut.s_q != prev_s}, 32'h1);
      end

      // Seed load and en together: the load wins.
      sv = 1'b1; sd = 32'h1; en = 1'b1;
      tick();
      sv = 1'b0; en = 1'b0;
      m_s = 32'h1; m_run = 1'b0;
      chk("prio_s", dut.s_q, m_s);
      chk("prio_ready", {31'h0, sr}, 32'h0);
      chk("prio_state", {30'h0, dut.state_q}, 32'h1);
      chk_out("prio");

      // Reset in the middle of RUN: outputs drop without a clock edge.
      for (int k = 0; k < 65; k++) tick();
      chk("pre_rst_valid", {31'h0, rv}, 32'h1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'h0, rv}, 32'h0);
      chk("midrst_ra", {28'h0, ra}, 32'h0);
      chk("midrst_rb", {28'h0, rb}, 32'h0);
      chk("midrst_ready", {31'h0, sr}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_valid", {31'h0, rv}, 32'h0);

      // Long random en stream from a fixed seed.
      sv = 1'b1; sd = 32'hDEAD_BEEF;
      tick();
      sv = 1'b0;
      for (int k = 0; k < 65; k++) begin
         en = 1'($urandom);
         tick();
      end
      m_s = ref_warm(32'hDEAD_BEEF, 64);
      m_run = 1'b1;
      chk_out("rnd_start");
      for (int k = 0; k < RAND_CYCLES; k++) begin
         en = 1'($urandom);
         tick();
         if (en) m_s = ref_adv(m_s);
         chk_out("rnd");
         chk("rnd_nonzero", {31'h0, dut.s_q != 32'h0}, 32'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
